// File: rtl/serial_add_pkg.sv
// Shared types for the serial-add scheduler.
//   sched_state_t : scheduler FSM states
//   req_id_t      : requester identifier (one bit, two requesters)
//   REQ0 / REQ1   : requester identifier constants
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder; the shared bit cell of the serial adder engine.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out (majority of the three inputs)
module full_adder_1b (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler for one shared LSB-first bit-serial adder.
// Two requesters offer {A, B, carry-in} on valid/ready; the winner's operands
// are captured, added over W clocks, and the sum/carry-out is returned tagged
// with the requester ID on a valid/ready result channel.
//   CLK_i, rst_i                 : clock, async active-high reset
//   reqN_valid_i / reqN_ready_o  : requester N handshake
//   reqN_A_i, reqN_B_i, reqN_P_i : requester N operands and carry-in
//   res_valid_o / res_ready_i    : result handshake
//   res_id_o                     : requester owning the result
//   S_o, C_o, full_add           : sum, carry-out, {C_o, S_o}
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         CLK_i,
  input  logic         rst_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [W-1:0] req0_A_i,
  input  logic [W-1:0] req0_B_i,
  input  logic         req0_P_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [W-1:0] req1_A_i,
  input  logic [W-1:0] req1_B_i,
  input  logic         req1_P_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic         res_id_o,
  output logic [W-1:0] S_o,
  output logic         C_o,
  output logic [W:0]   full_add
);

  localparam int CNT_W = $clog2(W);

  sched_state_t     state_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-2:0]     sh_q;        // partial sum; the newest bit lives in sum_d
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  req_id_t          id_q, last_grant_q, res_id_q;
  logic [W-1:0]     s_q;
  logic             co_q;
  logic             res_valid_q;

  logic             fa_s, fa_c;
  logic [W-1:0]     sum_d;
  req_id_t          grant;
  logic             grant_vld;
  logic             accept;

  full_adder_1b u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum bit enters at the MSB; after W shifts the register holds the sum.
  assign sum_d = {fa_s, sh_q};

  // Round-robin: on a tie the requester that did not win last time is chosen.
  always_comb begin
    grant     = REQ0;
    grant_vld = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant     = ~last_grant_q;
      grant_vld = 1'b1;
    end else if (req0_valid_i) begin
      grant     = REQ0;
      grant_vld = 1'b1;
    end else if (req1_valid_i) begin
      grant     = REQ1;
      grant_vld = 1'b1;
    end
  end

  // Ready is masked by reset so nothing looks accepted while reset is held.
  assign req0_ready_o = (state_q == ST_IDLE) && !rst_i && grant_vld && (grant == REQ0);
  assign req1_ready_o = (state_q == ST_IDLE) && !rst_i && grant_vld && (grant == REQ1);
  assign accept       = req0_ready_o || req1_ready_o;

  always_ff @(posedge CLK_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sh_q         <= '0;
      c_q          <= 1'b0;
      cnt_q        <= '0;
      id_q         <= REQ0;
      last_grant_q <= REQ1;
      res_id_q     <= REQ0;
      s_q          <= '0;
      co_q         <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q          <= (grant == REQ0) ? req0_A_i : req1_A_i;
            b_q          <= (grant == REQ0) ? req0_B_i : req1_B_i;
            c_q          <= (grant == REQ0) ? req0_P_i : req1_P_i;
            cnt_q        <= '0;
            id_q         <= grant;
            last_grant_q <= grant;
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q  <= {1'b0, a_q[W-1:1]};
          b_q  <= {1'b0, b_q[W-1:1]};
          c_q  <= fa_c;
          sh_q <= sum_d[W-1:1];
          if (cnt_q == CNT_W'(W - 1)) begin
            // Result registers change only here, so S_o never shows a partial sum.
            s_q         <= sum_d;
            co_q        <= fa_c;
            res_id_q    <= id_q;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign S_o         = s_q;
  assign C_o         = co_q;
  assign full_add    = {co_q, s_q};

endmodule

// File: tb/tb_serial_add_sched.sv
module tb_serial_add_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_P;
  logic [15:0] req0_A, req0_B;
  logic        req1_valid, req1_ready, req1_P;
  logic [15:0] req1_A, req1_B;
  logic        res_valid, res_ready, res_id, C;
  logic [15:0] S;
  logic [16:0] full_add;

  int checks = 0;
  int errors = 0;

  serial_add_sched #(.W(16)) dut (
    .CLK_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_A_i     (req0_A),
    .req0_B_i     (req0_B),
    .req0_P_i     (req0_P),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_A_i     (req1_A),
    .req1_B_i     (req1_B),
    .req1_P_i     (req1_P),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_id_o     (res_id),
    .S_o          (S),
    .C_o          (C),
    .full_add     (full_add)
  );

  always #5 clk = ~clk;

  // Issue one op on a single requester and wait for its result (bounded).
  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic p, output logic [15:0] s, output logic c,
                        output logic rid, output int lat, output bit ok);
    int n;
    ok = 1'b1; lat = 0; s = '0; c = 1'b0; rid = 1'b0;
    @(negedge clk);
    if (id == 1'b0) begin req0_valid = 1'b1; req0_A = a; req0_B = b; req0_P = p; end
    else            begin req1_valid = 1'b1; req1_A = a; req1_B = b; req1_P = p; end
    #1;
    n = 0;
    while (!((id == 1'b0) ? req0_ready : req1_ready) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) begin
      ok = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    while (lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (res_valid) break;
    end
    if (!res_valid) ok = 1'b0;
    s = S; c = C; rid = res_id;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (S !== 16'h0 || C !== 1'b0 || full_add !== 17'h0) begin
      errors++; $display("FAIL reset_result: S=%h C=%b full=%h, required 0", S, C, full_add);
    end
    checks++;
    if (res_valid !== 1'b0 || res_id !== 1'b0) begin
      errors++; $display("FAIL reset_valid_id: valid=%b id=%b, required 0 0", res_valid, res_id);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: r0=%b r1=%b, required 0 0", req0_ready, req1_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_first_tie: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL drop_valid_ready: r0=%b r1=%b, required 0 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [15:0] s; logic c, rid; int lat; bit ok;
    run_op(1'b0, 16'h1234, 16'h4321, 1'b0, s, c, rid, lat, ok);
    checks++;
    if (!ok || s !== 16'h5555 || c !== 1'b0 || rid !== 1'b0) begin
      errors++; $display("FAIL basic_sum: ok=%0d S=%h C=%b id=%b, required S=5555 C=0 id=0", ok, s, c, rid);
    end
    checks++;
    if (lat != 16) begin
      errors++; $display("FAIL basic_latency: got %0d edges, required 16", lat);
    end
    $display("test_basic: S=%h C=%b id=%b lat=%0d", s, c, rid, lat);
  endtask

  task automatic test_overflow();
    logic [15:0] s; logic c, rid; int lat; bit ok;
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, s, c, rid, lat, ok);
    checks++;
    if (!ok || s !== 16'h0000 || c !== 1'b1 || full_add !== 17'h10000) begin
      errors++; $display("FAIL ovf_wrap: S=%h C=%b full=%h, required 0000 1 10000", s, c, full_add);
    end
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, s, c, rid, lat, ok);
    checks++;
    if (!ok || s !== 16'hFFFF || c !== 1'b1 || rid !== 1'b1) begin
      errors++; $display("FAIL ovf_max: S=%h C=%b id=%b, required FFFF 1 1", s, c, rid);
    end
    $display("test_overflow: last S=%h C=%b", s, c);
  endtask

  task automatic test_hold();
    logic [15:0] s; logic c, rid; int lat, n; bit ok;
    res_ready = 1'b0;
    run_op(1'b0, 16'h0F0F, 16'h0101, 1'b0, s, c, rid, lat, ok);
    checks++;
    if (!ok || s !== 16'h1010 || c !== 1'b0) begin
      errors++; $display("FAIL hold_first: S=%h C=%b, required 1010 0", s, c);
    end
    req1_valid = 1'b1; req1_A = 16'h1111; req1_B = 16'h2222; req1_P = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || S !== 16'h1010 || res_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b S=%h id=%b r0=%b r1=%b, required 1 1010 0 0 0",
                 i, res_valid, S, res_id, req0_ready, req1_ready);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: valid=%b r1=%b, required 0 1", res_valid, req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 40);
    checks++;
    if (res_valid !== 1'b1 || S !== 16'h3334 || C !== 1'b0 || res_id !== 1'b1) begin
      errors++; $display("FAIL hold_pending: valid=%b S=%h C=%b id=%b, required 1 3334 0 1", res_valid, S, C, res_id);
    end
    @(posedge clk); #1;
    $display("test_hold: pending result S=%h id=%b", S, res_id);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea [4];
    logic [15:0] eb [4];
    logic        ep [4];
    logic [16:0] er [4];
    int acc, res_idx, next_entry, last_cyc;
    logic g0, g1;
    ea = '{16'h0001, 16'h8000, 16'h00FF, 16'hAAAA};
    eb = '{16'h0002, 16'h8000, 16'h0F01, 16'h5555};
    ep = '{1'b0, 1'b0, 1'b1, 1'b1};
    er = '{17'h00003, 17'h10000, 17'h01001, 17'h10000};
    acc = 0; res_idx = 0; next_entry = 2; last_cyc = 0;
    req0_valid = 1'b1; req0_A = ea[0]; req0_B = eb[0]; req0_P = ep[0];
    req1_valid = 1'b1; req1_A = ea[1]; req1_B = eb[1]; req1_P = ep[1];
    for (int cyc = 0; cyc < 200 && res_idx < 4; cyc++) begin
      @(negedge clk);
      if (res_valid) begin
        checks++;
        if ({C, S} !== er[res_idx] || res_id !== 1'(res_idx % 2)) begin
          errors++; $display("FAIL b2b_result[%0d]: {C,S}=%h id=%b, required %h %0d",
                             res_idx, {C, S}, res_id, er[res_idx], res_idx % 2);
        end
        $display("b2b result %0d: {C,S}=%h id=%b", res_idx, {C, S}, res_id);
        res_idx++;
      end
      g0 = req0_ready; g1 = req1_ready;
      if (g0 || g1) begin
        checks++;
        if (g1 !== 1'(acc % 2) || (g0 && g1)) begin
          errors++; $display("FAIL b2b_grant[%0d]: r0=%b r1=%b, required grant %0d", acc, g0, g1, acc % 2);
        end
        if (acc > 0) begin
          checks++;
          if (cyc - last_cyc != 18) begin
            errors++; $display("FAIL b2b_cadence[%0d]: got %0d clocks, required 18", acc, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        acc++;
      end
      @(posedge clk); #1;
      if (g0) begin
        if (next_entry < 4) begin
          req0_A = ea[next_entry]; req0_B = eb[next_entry]; req0_P = ep[next_entry]; next_entry++;
        end else req0_valid = 1'b0;
      end
      if (g1) begin
        if (next_entry < 4) begin
          req1_A = ea[next_entry]; req1_B = eb[next_entry]; req1_P = ep[next_entry]; next_entry++;
        end else req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (res_idx != 4) begin
      errors++; $display("FAIL b2b_count: got %0d results, required 4", res_idx);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic c, rid; int lat; bit ok, bad;
    @(negedge clk);
    req0_valid = 1'b1; req0_A = 16'h1234; req0_B = 16'h1111; req0_P = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_accept: r0=%b, required 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (S !== 16'h0 || C !== 1'b0 || full_add !== 17'h0 || res_valid !== 1'b0 || res_id !== 1'b0) begin
      errors++; $display("FAIL rmid_clear: S=%h C=%b full=%h valid=%b id=%b, required all 0",
                         S, C, full_add, res_valid, res_id);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || S !== 16'h0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rmid_no_result: valid=%b S=%h after abort, required 0 0000", res_valid, S);
    end
    run_op(1'b1, 16'h1234, 16'h1111, 1'b1, s, c, rid, lat, ok);
    checks++;
    if (!ok || s !== 16'h2346 || c !== 1'b0 || rid !== 1'b1 || lat != 16) begin
      errors++; $display("FAIL rmid_reissue: S=%h C=%b id=%b lat=%0d, required 2346 0 1 16", s, c, rid, lat);
    end
    $display("test_reset_mid: reissue S=%h", s);
  endtask

  task automatic test_random();
    logic [16:0] exp_q[$];
    logic        exp_id_q[$];
    logic [16:0] e;
    logic        eid;
    int acc, done;
    acc = 0; done = 0;
    for (int cyc = 0; cyc < 60000 && done < 1000; cyc++) begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected: {C,S}=%h id=%b, required no result", {C, S}, res_id);
        end else begin
          e = exp_q.pop_front(); eid = exp_id_q.pop_front();
          if ({C, S} !== e || res_id !== eid) begin
            errors++; $display("FAIL rand_result[%0d]: {C,S}=%h id=%b, required %h %b", done, {C, S}, res_id, e, eid);
          end
        end
        done++;
      end
      if (req0_ready) begin
        exp_q.push_back(17'(req0_A) + 17'(req0_B) + 17'(req0_P)); exp_id_q.push_back(1'b0); acc++;
      end
      if (req1_ready) begin
        exp_q.push_back(17'(req1_A) + 17'(req1_B) + 17'(req1_P)); exp_id_q.push_back(1'b1); acc++;
      end
      @(posedge clk); #1;
      if (acc < 1000) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_A = 16'($urandom); req0_B = 16'($urandom); req0_P = 1'($urandom);
        req1_valid = 1'($urandom_range(0, 1)); req1_A = 16'($urandom); req1_B = 16'($urandom); req1_P = 1'($urandom);
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    res_ready = 1'b1;
    checks++;
    if (done != 1000) begin
      errors++; $display("FAIL rand_count: got %0d results, required 1000", done);
    end
    $display("test_random: %0d ops accepted, %0d results", acc, done);
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_A = '0; req0_B = '0; req0_P = 1'b0;
    req1_valid = 1'b1; req1_A = '0; req1_B = '0; req1_P = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
